// File: rtl/io_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : io_bus_arbiter
// Description : Two-requester round-robin arbiter for the IO port block.
//               Each transaction runs IDLE -> ACCESS -> CAPTURE -> RESP.
// Revision    : 1.0 - initial release
// ============================================================================
module io_bus_arbiter (
    input  logic        clock,
    input  logic        resetn,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [4:0]  addr0,
    input  logic [4:0]  addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata,
    output logic        err,
    output logic [4:0]  io_addr,
    output logic [31:0] io_datain,
    output logic        io_we,
    input  logic [31:0] io_dataout
);

    localparam logic [4:0] C_PARK_ADDR   = 5'b11111;
    localparam logic [4:0] C_MAX_WR_ADDR = 5'd5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_ptr;      // last granted requester; also owner of the live transaction
    logic        r_we;
    logic [4:0]  r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        w_any;
    logic        w_win;
    logic        w_wr_ok;

    assign w_any   = req0 | req1;
    assign w_win   = (req0 & req1) ? ~r_ptr : req1;
    assign w_wr_ok = r_we && (r_addr <= C_MAX_WR_ADDR);
    assign rdata   = r_rdata;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_ptr   <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= 5'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_any) begin
                r_ptr   <= w_win;
                r_we    <= w_win ? we1    : we0;
                r_addr  <= w_win ? addr1  : addr0;
                r_wdata <= w_win ? wdata1 : wdata0;
            end
            if (r_state == ST_CAPTURE) begin
                r_rdata <= r_we ? 32'd0 : io_dataout;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        rvalid0   = 1'b0;
        rvalid1   = 1'b0;
        err       = 1'b0;
        io_addr   = C_PARK_ADDR;
        io_datain = 32'd0;
        io_we     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) w_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                w_next    = ST_CAPTURE;
                gnt0      = ~r_ptr;
                gnt1      = r_ptr;
                io_addr   = r_addr;
                io_datain = r_wdata;
                io_we     = w_wr_ok;
            end
            ST_CAPTURE: begin
                w_next = ST_RESP;
            end
            ST_RESP: begin
                w_next  = ST_IDLE;
                rvalid0 = ~r_ptr;
                rvalid1 = r_ptr;
                err     = r_we & ~w_wr_ok;
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_io_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_bus_arbiter
// Description : Directed self-checking bench for io_bus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req0, req1, we0, we1;
    logic [4:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err, io_we;
    logic [31:0] rdata, io_datain, io_dataout;
    logic [4:0]  io_addr;

    int n_vec = 0;
    int n_err = 0;

    io_bus_arbiter dut (
        .clock(clk), .resetn(resetn),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .err(err), .io_addr(io_addr), .io_datain(io_datain),
        .io_we(io_we), .io_dataout(io_dataout)
    );

    always #5 clk = ~clk;

    // Packed view of the request-side outputs: {gnt0,gnt1,io_we,io_addr,io_datain}
    logic [39:0] w_acc;
    // Packed view of the response-side outputs: {rvalid0,rvalid1,err,rdata}
    logic [34:0] w_rsp;
    assign w_acc = {gnt0, gnt1, io_we, io_addr, io_datain};
    assign w_rsp = {rvalid0, rvalid1, err, rdata};

    task automatic test_reset;
        resetn = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; io_dataout = 0;
        #1;
        n_vec++;
        if (w_acc !== {3'b000, 5'h1F, 32'd0}) begin
            n_err++; $display("FAIL reset_acc got %h exp %h", w_acc, {3'b000, 5'h1F, 32'd0});
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if (w_rsp !== 35'd0) begin
            n_err++; $display("FAIL reset_rsp got %h exp 0", w_rsp);
        end
        resetn = 1'b1;
    endtask

    task automatic test_write;
        @(negedge clk);
        req0 = 1; we0 = 1; addr0 = 5'd2; wdata0 = 32'h7;
        @(negedge clk);
        n_vec++;
        if (w_acc !== {3'b101, 5'd2, 32'h7}) begin
            n_err++; $display("FAIL wr_access got %h exp %h", w_acc, {3'b101, 5'd2, 32'h7});
        end
        @(negedge clk);
        n_vec++;
        if ({w_acc, w_rsp} !== {3'b000, 5'h1F, 32'd0, 35'd0}) begin
            n_err++; $display("FAIL wr_capture got %h/%h exp idle outputs", w_acc, w_rsp);
        end
        @(negedge clk);
        n_vec++;
        if (w_rsp !== {3'b100, 32'd0}) begin
            n_err++; $display("FAIL wr_resp got %h exp %h", w_rsp, {3'b100, 32'd0});
        end
        req0 = 0;
        @(negedge clk);
        n_vec++;
        if (w_rsp[34:33] !== 2'b00) begin
            n_err++; $display("FAIL wr_rvalid_pulse got %b exp 00", w_rsp[34:33]);
        end
    endtask

    task automatic test_read;
        @(negedge clk);
        req1 = 1; we1 = 0; addr1 = 5'd16; wdata1 = 32'hDEAD; io_dataout = 32'h2A5;
        @(negedge clk);
        n_vec++;
        if (w_acc !== {3'b010, 5'd16, 32'hDEAD}) begin
            n_err++; $display("FAIL rd_access got %h exp %h", w_acc, {3'b010, 5'd16, 32'hDEAD});
        end
        @(negedge clk);
        n_vec++;
        if (io_we !== 1'b0) begin
            n_err++; $display("FAIL rd_capture_we got %b exp 0", io_we);
        end
        @(negedge clk);
        n_vec++;
        if (w_rsp !== {3'b010, 32'h2A5}) begin
            n_err++; $display("FAIL rd_resp got %h exp %h", w_rsp, {3'b010, 32'h2A5});
        end
        req1 = 0;
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        logic [3:0] exp;
        test_reset;
        @(negedge clk);
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 5'd3; addr1 = 5'd4; io_dataout = 32'h11;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp = {(k % 8 == 1), (k % 8 == 5), (k % 8 == 3), (k % 8 == 7)};
            n_vec++;
            if ({gnt0, gnt1, rvalid0, rvalid1} !== exp) begin
                n_err++;
                $display("FAIL rr_cycle%0d got %b exp %b", k, {gnt0, gnt1, rvalid0, rvalid1}, exp);
            end
        end
        req0 = 0; req1 = 0;
        @(negedge clk);
    endtask

    task automatic test_suppressed_write;
        @(negedge clk);
        req0 = 1; we0 = 1; addr0 = 5'd9; wdata0 = 32'hABCD; io_dataout = 32'h55;
        @(negedge clk);
        n_vec++;
        if (w_acc !== {3'b100, 5'd9, 32'hABCD}) begin
            n_err++; $display("FAIL sup_access got %h exp %h", w_acc, {3'b100, 5'd9, 32'hABCD});
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if (w_rsp !== {3'b101, 32'd0}) begin
            n_err++; $display("FAIL sup_resp got %h exp %h", w_rsp, {3'b101, 32'd0});
        end
        req0 = 0;
        @(negedge clk);
    endtask

    task automatic test_addr_boundary;
        for (int a = 5; a <= 6; a++) begin
            @(negedge clk);
            req1 = 1; we1 = 1; addr1 = a[4:0]; wdata1 = 32'h100 + a;
            @(negedge clk);
            n_vec++;
            if (io_we !== (a == 5)) begin
                n_err++; $display("FAIL bnd_we_addr%0d got %b exp %b", a, io_we, (a == 5));
            end
            repeat (2) @(negedge clk);
            n_vec++;
            if ({rvalid1, err} !== {1'b1, (a == 6)}) begin
                n_err++; $display("FAIL bnd_err_addr%0d got %b exp %b", a, {rvalid1, err}, {1'b1, (a == 6)});
            end
            req1 = 0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_txn;
        int seen;
        @(negedge clk);
        req1 = 1; we1 = 0; addr1 = 5'd4; io_dataout = 32'h77;
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        #1;
        n_vec++;
        if ({w_acc, w_rsp} !== {3'b000, 5'h1F, 32'd0, 35'd0}) begin
            n_err++; $display("FAIL rst_mid got %h/%h exp idle outputs", w_acc, w_rsp);
        end
        @(negedge clk);
        resetn = 1'b1; req1 = 0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (rvalid0 | rvalid1 | gnt0 | gnt1) seen++;
        end
        n_vec++;
        if (seen !== 0) begin
            n_err++; $display("FAIL rst_abandon got %0d activity cycles exp 0", seen);
        end
        req0 = 1; we0 = 1; addr0 = 5'd1; wdata0 = 32'h3C;
        @(negedge clk);
        n_vec++;
        if (w_acc !== {3'b101, 5'd1, 32'h3C}) begin
            n_err++; $display("FAIL rst_after_access got %h exp %h", w_acc, {3'b101, 5'd1, 32'h3C});
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if (w_rsp !== {3'b100, 32'd0}) begin
            n_err++; $display("FAIL rst_after_resp got %h exp %h", w_rsp, {3'b100, 32'd0});
        end
        req0 = 0;
        @(negedge clk);
    endtask

    task automatic test_drop_req;
        @(negedge clk);
        req0 = 1; we0 = 0; addr0 = 5'd3; io_dataout = 32'h1234;
        @(negedge clk);
        n_vec++;
        if (gnt0 !== 1'b1) begin
            n_err++; $display("FAIL drop_gnt0 got %b exp 1", gnt0);
        end
        req0 = 0; addr0 = 5'd20;
        repeat (2) @(negedge clk);
        n_vec++;
        if (w_rsp !== {3'b100, 32'h1234}) begin
            n_err++; $display("FAIL drop_resp got %h exp %h", w_rsp, {3'b100, 32'h1234});
        end
        @(negedge clk);
        n_vec++;
        if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0000) begin
            n_err++; $display("FAIL drop_idle got %b exp 0000", {gnt0, gnt1, rvalid0, rvalid1});
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_round_robin;
        test_suppressed_write;
        test_addr_boundary;
        test_reset_mid_txn;
        test_drop_req;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
